// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction fetch/execute sequencer.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Branch displacement: sign-extended word offset turned into a byte offset.
  function automatic word_t branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: register jump, absolute jump, taken branch, sequential.
module pc_next_logic
  import cpu_types_pkg::*;
(
  input  word_t       pc,
  input  logic [25:0] target,
  input  logic        J,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        Beq,
  input  logic        Bne,
  input  logic        zero,
  input  word_t       rs_data,
  output word_t       pc_plus4,
  output word_t       next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    if (Jr)
      next_pc = rs_data;
    else if (J | Jal)
      next_pc = {pc_plus4[31:28], target, 2'b00};
    else if ((Beq & zero) | (Bne & ~zero))
      next_pc = pc_plus4 + branch_offset(target[15:0]);
    else
      next_pc = pc_plus4;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer owning the PC and instruction register.
// state  | meaning
// FETCH  | instruction read outstanding, wait for ihit
// EXEC   | Instr decoded by control unit; retire, go to MEM, or halt
// MEM    | data access outstanding, retire on dhit
// HALTED | frozen until reset
module fetch_sequencer
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  input  logic  dhit,
  input  logic  J,
  input  logic  Jal,
  input  logic  Jr,
  input  logic  Beq,
  input  logic  Bne,
  input  logic  Halt,
  input  logic  MemtoReg,
  input  logic  MemWr,
  input  logic  zero,
  input  word_t rs_data,
  output logic  imemREN,
  output word_t imemaddr,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t Instr,
  output word_t pc_plus4,
  output logic  commit,
  output logic  halt
);

  fetch_state_t state;
  word_t        pc;
  word_t        next_pc;
  logic         mem_op;

  pc_next_logic u_pc_next (
    .pc       (pc),
    .target   (Instr[25:0]),
    .J        (J),
    .Jal      (Jal),
    .Jr       (Jr),
    .Beq      (Beq),
    .Bne      (Bne),
    .zero     (zero),
    .rs_data  (rs_data),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  assign mem_op = MemtoReg | MemWr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
      pc    <= PC_INIT;
      Instr <= '0;
    end else begin
      case (state)
        FETCH: if (ihit) begin
          Instr <= iload;
          state <= EXEC;
        end
        EXEC: begin
          if (Halt)
            state <= HALTED;
          else if (mem_op)
            state <= MEM;
          else begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        MEM: if (dhit) begin
          pc    <= next_pc;
          state <= FETCH;
        end
        HALTED: state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

  // Requests decode from the registered state, so async reset clears them at once.
  // A read wins if the control unit ever flags both, keeping the strobes exclusive.
  assign imemaddr = pc;
  assign imemREN  = (state == FETCH);
  assign dmemREN  = (state == MEM) & MemtoReg;
  assign dmemWEN  = (state == MEM) & MemWr & ~MemtoReg;
  assign commit   = ((state == EXEC) & ~Halt & ~mem_op) | ((state == MEM) & dhit);
  assign halt     = (state == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a cycle-level reference model and per-cycle compare.
module tb_fetch_sequencer;
  import cpu_types_pkg::*;

  localparam word_t PC_INIT = 32'h0000_0000;

  localparam word_t I_ADDI = 32'h2001_0005;
  localparam word_t I_BEQ  = 32'h1022_FFFF;
  localparam word_t I_BNE  = 32'h1422_0003;
  localparam word_t I_LW   = 32'h8C41_0000;
  localparam word_t I_SW   = 32'hAC41_0004;
  localparam word_t I_J    = 32'h0800_0100;
  localparam word_t I_JX   = 32'h0800_0123;
  localparam word_t I_JAL  = 32'h0C00_0040;
  localparam word_t I_JR   = 32'h03E0_0008;
  localparam word_t I_HALT = 32'hFC00_0000;

  // control vector order: {J, Jal, Jr, Beq, Bne, Halt, MemtoReg, MemWr}
  localparam logic [7:0] C_J = 8'h80, C_JAL = 8'h40, C_JR = 8'h20, C_BEQ = 8'h10;
  localparam logic [7:0] C_BNE = 8'h08, C_HALT = 8'h04, C_MR = 8'h02, C_MW = 8'h01;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  ihit = 1'b0, dhit = 1'b0;
  word_t iload = '0;
  logic  J = 0, Jal = 0, Jr = 0, Beq = 0, Bne = 0, Halt = 0, MemtoReg = 0, MemWr = 0;
  logic  zero = 0;
  word_t rs_data = '0;
  logic  imemREN, dmemREN, dmemWEN, commit, halt;
  word_t imemaddr, Instr, pc_plus4;

  fetch_sequencer #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .dhit(dhit),
    .J(J), .Jal(Jal), .Jr(Jr), .Beq(Beq), .Bne(Bne), .Halt(Halt),
    .MemtoReg(MemtoReg), .MemWr(MemWr), .zero(zero), .rs_data(rs_data),
    .imemREN(imemREN), .imemaddr(imemaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .Instr(Instr), .pc_plus4(pc_plus4), .commit(commit), .halt(halt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err = 0;
  int n_iren = 0, n_dren = 0, n_dwen = 0, n_commit = 0, n_halt = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which step of the instruction life-cycle we are in, the PC and the IR.
  localparam int PH_FETCH = 0, PH_EXEC = 1, PH_MEM = 2, PH_HALT = 3;
  int    m_phase = PH_FETCH;
  word_t m_pc = PC_INIT;
  word_t m_instr = '0;

  function automatic word_t model_target();
    word_t seq;
    int    off;
    seq = m_pc + 32'd4;
    off = $signed(m_instr[15:0]);
    if (Jr) return rs_data;
    if (J || Jal) return {seq[31:28], m_instr[25:0], 2'b00};
    if ((Beq && zero) || (Bne && !zero)) return seq + word_t'(off * 4);
    return seq;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase = PH_FETCH;
      m_pc    = PC_INIT;
      m_instr = '0;
    end else if (m_phase == PH_FETCH && ihit) begin
      m_instr = iload;
      m_phase = PH_EXEC;
    end else if (m_phase == PH_EXEC) begin
      if (Halt) m_phase = PH_HALT;
      else if (MemtoReg || MemWr) m_phase = PH_MEM;
      else begin
        m_pc    = model_target();
        m_phase = PH_FETCH;
      end
    end else if (m_phase == PH_MEM && dhit) begin
      m_pc    = model_target();
      m_phase = PH_FETCH;
    end
  end

  logic e_ir, e_dr, e_dw, e_cm, e_h;
  always @(negedge CLK) begin
    e_ir = (m_phase == PH_FETCH);
    e_dr = (m_phase == PH_MEM) && MemtoReg;
    e_dw = (m_phase == PH_MEM) && MemWr && !MemtoReg;
    e_cm = ((m_phase == PH_EXEC) && !Halt && !MemtoReg && !MemWr) || ((m_phase == PH_MEM) && dhit);
    e_h  = (m_phase == PH_HALT);
    check("imemREN", 32'(imemREN), 32'(e_ir));
    check("dmemREN", 32'(dmemREN), 32'(e_dr));
    check("dmemWEN", 32'(dmemWEN), 32'(e_dw));
    check("commit", 32'(commit), 32'(e_cm));
    check("halt", 32'(halt), 32'(e_h));
    check("imemaddr", imemaddr, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("Instr", Instr, m_instr);
    check("req_exclusive", 32'(int'(imemREN) + int'(dmemREN) + int'(dmemWEN) > 1), 32'd0);
    n_iren   += int'(imemREN);
    n_dren   += int'(dmemREN);
    n_dwen   += int'(dmemWEN);
    n_commit += int'(commit);
    n_halt   += int'(halt);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    #2;
  endtask

  task automatic set_ctl(input logic [7:0] c);
    {J, Jal, Jr, Beq, Bne, Halt, MemtoReg, MemWr} = c;
  endtask

  task automatic clr_counts();
    n_iren = 0; n_dren = 0; n_dwen = 0; n_commit = 0; n_halt = 0;
  endtask

  // Fetch one instruction, present its decode, and (for loads/stores) hold dhit off for dwait cycles.
  task automatic run_instr(input word_t iw, input logic [7:0] c, input word_t rs, input logic z,
                           input int dwait);
    ihit = 1'b1; iload = iw; dhit = 1'b1;
    step();
    ihit = 1'b0; dhit = 1'b0; iload = 32'hDEAD_BEEF;
    set_ctl(c); rs_data = rs; zero = z;
    clr_counts();
    step();
    if ((c & C_HALT) == 8'h00 && (c & (C_MR | C_MW)) != 8'h00) begin
      for (int k = 0; k < dwait; k++) begin
        ihit = 1'b1;
        step();
      end
      ihit = 1'b0; dhit = 1'b1;
      step();
      dhit = 1'b0;
    end
    set_ctl(8'h00); rs_data = '0; zero = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    check("rst_imemaddr", imemaddr, PC_INIT);
    check("rst_Instr", Instr, 32'h0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_imemREN", 32'(imemREN), 32'd1);
    #2 RST = 1'b0;

    step(); mid();
    check("first_fetch_addr", imemaddr, 32'h0);
    ihit = 1'b1; iload = I_ADDI; dhit = 1'b1;
    step();
    ihit = 1'b0; dhit = 1'b0; iload = 32'hDEAD_BEEF;
    mid();
    check("addi_instr", Instr, I_ADDI);
    check("addi_commit", 32'(commit), 32'd1);
    step(); mid();
    check("addi_pc", imemaddr, 32'h4);
    check("addi_commit_done", 32'(commit), 32'd0);

    run_instr(I_JR, C_JR, 32'h10, 1'b0, 0);
    run_instr(I_BEQ, C_BEQ, '0, 1'b1, 0); mid();
    check("beq_taken_back", imemaddr, 32'h10);
    run_instr(I_BEQ, C_BEQ, '0, 1'b0, 0); mid();
    check("beq_not_taken", imemaddr, 32'h14);
    run_instr(I_JR, C_JR, 32'h10, 1'b0, 0);
    run_instr(I_BNE, C_BNE, '0, 1'b0, 0); mid();
    check("bne_taken", imemaddr, 32'h20);
    run_instr(I_BNE, C_BNE, '0, 1'b1, 0); mid();
    check("bne_not_taken", imemaddr, 32'h24);

    run_instr(I_LW, C_MR, '0, 1'b0, 3);
    check("lw_dmemREN_cycles", 32'(n_dren), 32'd4);
    check("lw_imemREN_cycles", 32'(n_iren), 32'd0);
    check("lw_commit_count", 32'(n_commit), 32'd1);
    mid();
    check("lw_pc", imemaddr, 32'h28);

    run_instr(I_JX, C_JR | C_J, 32'h400, 1'b0, 0); mid();
    check("jr_over_j", imemaddr, 32'h400);
    run_instr(I_JR, C_JR, 32'hF000_0000, 1'b0, 0);
    run_instr(I_J, C_J, '0, 1'b0, 0); mid();
    check("j_region", imemaddr, 32'hF000_0400);
    check("jal_link", pc_plus4, 32'hF000_0404);
    run_instr(I_JAL, C_JAL, '0, 1'b0, 0); mid();
    check("jal_target", imemaddr, 32'hF000_0100);

    run_instr(I_JR, C_JR, 32'hFFFF_FFFC, 1'b0, 0); mid();
    check("wrap_plus4", pc_plus4, 32'h0);
    run_instr(I_ADDI, 8'h00, '0, 1'b0, 0); mid();
    check("wrap_pc", imemaddr, 32'h0);

    run_instr(I_SW, C_MW, '0, 1'b0, 2);
    check("sw_dmemWEN_cycles", 32'(n_dwen), 32'd3);
    check("sw_dmemREN_cycles", 32'(n_dren), 32'd0);
    mid();
    check("sw_pc", imemaddr, 32'h4);

    ihit = 1'b1; iload = I_HALT;
    step();
    ihit = 1'b0; iload = 32'hDEAD_BEEF;
    set_ctl(C_HALT);
    step();
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; dhit = ~i[0];
      step();
    end
    ihit = 1'b0; dhit = 1'b0;
    check("halt_no_requests", 32'(n_iren + n_dren + n_dwen), 32'd0);
    check("halt_no_commit", 32'(n_commit), 32'd0);
    check("halt_sticky", 32'(n_halt), 32'd10);
    mid();
    check("halt_pc_frozen", imemaddr, 32'h4);
    check("halt_instr_frozen", Instr, I_HALT);
    RST = 1'b1;
    #1;
    check("halt_reset_clear", 32'(halt), 32'd0);
    check("halt_reset_pc", imemaddr, PC_INIT);
    set_ctl(8'h00);
    #3 RST = 1'b0;

    step();
    ihit = 1'b1; iload = I_SW;
    step();
    ihit = 1'b0; iload = 32'hDEAD_BEEF;
    set_ctl(C_MW);
    step(); mid();
    check("sw_wen_before_rst", 32'(dmemWEN), 32'd1);
    RST = 1'b1;
    #1;
    check("sw_rst_wen_drop", 32'(dmemWEN), 32'd0);
    check("sw_rst_pc", imemaddr, PC_INIT);
    check("sw_rst_instr", Instr, 32'h0);
    check("sw_rst_commit", 32'(commit), 32'd0);
    #3 RST = 1'b0;
    set_ctl(8'h00);
    step(); mid();
    check("post_rst_imemREN", 32'(imemREN), 32'd1);
    check("post_rst_addr", imemaddr, PC_INIT);

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
